// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern, segment index and decoder FSM constants
package seg7_pkg;

    // Segment bit positions inside an active-high pattern {g,f,e,d,c,b,a}
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG7_PAT_0     = 7'h3F;
    localparam logic [6:0] SEG7_PAT_1     = 7'h06;
    localparam logic [6:0] SEG7_PAT_2     = 7'h5B;
    localparam logic [6:0] SEG7_PAT_3     = 7'h4F;
    localparam logic [6:0] SEG7_PAT_4     = 7'h66;
    localparam logic [6:0] SEG7_PAT_5     = 7'h6D;
    localparam logic [6:0] SEG7_PAT_6     = 7'h7D;
    localparam logic [6:0] SEG7_PAT_7     = 7'h07;
    localparam logic [6:0] SEG7_PAT_8     = 7'h7F;
    localparam logic [6:0] SEG7_PAT_9     = 7'h6F;
    localparam logic [6:0] SEG7_PAT_A     = 7'h77;
    localparam logic [6:0] SEG7_PAT_B     = 7'h7C;
    localparam logic [6:0] SEG7_PAT_C     = 7'h39;
    localparam logic [6:0] SEG7_PAT_D     = 7'h5E;
    localparam logic [6:0] SEG7_PAT_E     = 7'h79;
    localparam logic [6:0] SEG7_PAT_F     = 7'h71;
    localparam logic [6:0] SEG7_PAT_BLANK = 7'h00;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage

// File: rtl/seg7_pat_decode.sv
// rtl/seg7_pat_decode.sv - active-high 7-segment pattern to hex digit / blank / bad
module seg7_pat_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] digit,
    output logic       blank,
    output logic       bad
);

    always_comb begin
        digit = 4'h0;
        blank = 1'b0;
        bad   = 1'b0;
        case (pat)
            SEG7_PAT_0:     digit = 4'h0;
            SEG7_PAT_1:     digit = 4'h1;
            SEG7_PAT_2:     digit = 4'h2;
            SEG7_PAT_3:     digit = 4'h3;
            SEG7_PAT_4:     digit = 4'h4;
            SEG7_PAT_5:     digit = 4'h5;
            SEG7_PAT_6:     digit = 4'h6;
            SEG7_PAT_7:     digit = 4'h7;
            SEG7_PAT_8:     digit = 4'h8;
            SEG7_PAT_9:     digit = 4'h9;
            SEG7_PAT_A:     digit = 4'hA;
            SEG7_PAT_B:     digit = 4'hB;
            SEG7_PAT_C:     digit = 4'hC;
            SEG7_PAT_D:     digit = 4'hD;
            SEG7_PAT_E:     digit = 4'hE;
            SEG7_PAT_F:     digit = 4'hF;
            SEG7_PAT_BLANK: blank = 1'b1;
            default:        bad   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed two-digit 7-segment monitor; SEG7_SCAN_DECODER_STALL_EN adds a stall flag
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int STALL_CYCLES  = 1000000
) (
    input  logic       CLK,
    input  logic       BTN_N,
    input  logic [6:0] seg_n,
    input  logic       dig_sel,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       ones_blank,
    output logic       tens_blank,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       value_changed,
    output logic       stalled
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [6:0] seg_s1, seg_s2;
    logic       dsel_s1, dsel_s2;
    logic [7:0] stable_cnt, stable_next;
    logic [1:0] state, state_next;
    logic       changing, dsel_edge, capture;
    logic [3:0] dec_digit;
    logic       dec_blank, dec_bad;
    logic       ones_flag;
    logic [3:0] pend_digit;
    logic       pend_blank, pend_bad;

    always_ff @(posedge CLK or negedge BTN_N) begin
        if (!BTN_N) begin
            seg_s1  <= '0;
            seg_s2  <= '0;
            dsel_s1 <= 1'b0;
            dsel_s2 <= 1'b0;
        end else begin
            seg_s1  <= seg_n;
            seg_s2  <= seg_s1;
            dsel_s1 <= dig_sel;
            dsel_s2 <= dsel_s1;
        end
    end

    // Looking one stage ahead lets the counter clear on the same edge the synchronised value moves
    assign dsel_edge = dsel_s1 != dsel_s2;
    assign changing  = dsel_edge || (seg_s1 != seg_s2);

    always_comb begin
        stable_next = stable_cnt;
        if (changing)
            stable_next = 8'd0;
        else if (stable_cnt != STABLE_MAX)
            stable_next = stable_cnt + 8'd1;
    end

    always_ff @(posedge CLK or negedge BTN_N) begin
        if (!BTN_N)
            stable_cnt <= 8'd0;
        else
            stable_cnt <= stable_next;
    end

    assign capture = (state == ST_SETTLE) && (stable_next == STABLE_MAX);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (dsel_edge) state_next = ST_SETTLE;
            ST_SETTLE: if (capture)   state_next = ST_HOLD;
            ST_HOLD:   if (changing)  state_next = ST_SETTLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge BTN_N) begin
        if (!BTN_N)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    seg7_pat_decode u_decode (
        .pat   (~seg_s2),
        .digit (dec_digit),
        .blank (dec_blank),
        .bad   (dec_bad)
    );

    always_ff @(posedge CLK or negedge BTN_N) begin
        if (!BTN_N) begin
            ones_flag     <= 1'b0;
            pend_digit    <= 4'h0;
            pend_blank    <= 1'b0;
            pend_bad      <= 1'b0;
            ones          <= 4'h0;
            tens          <= 4'h0;
            ones_blank    <= 1'b0;
            tens_blank    <= 1'b0;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            value_changed <= 1'b0;
        end else begin
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            value_changed <= 1'b0;
            if (capture) begin
                if (!dsel_s2) begin
                    // A repeated ones phase simply overwrites the pending digit
                    ones_flag  <= 1'b1;
                    pend_digit <= dec_digit;
                    pend_blank <= dec_blank;
                    pend_bad   <= dec_bad;
                end else if (ones_flag) begin
                    ones_flag   <= 1'b0;
                    frame_valid <= 1'b1;
                    if (pend_bad || dec_bad) begin
                        frame_err <= 1'b1;
                    end else begin
                        ones          <= pend_digit;
                        tens          <= dec_digit;
                        ones_blank    <= pend_blank;
                        tens_blank    <= dec_blank;
                        value_changed <= {dec_digit, pend_digit, dec_blank, pend_blank}
                                         != {tens, ones, tens_blank, ones_blank};
                    end
                end
            end
        end
    end

`ifdef SEG7_SCAN_DECODER_STALL_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

    logic [STALL_W-1:0] stall_cnt;

    always_ff @(posedge CLK or negedge BTN_N) begin
        if (!BTN_N)
            stall_cnt <= '0;
        else if (dsel_edge)
            stall_cnt <= '0;
        else if (stall_cnt != STALL_MAX)
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign stalled = (stall_cnt == STALL_MAX);
`else
    assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int STABLE = 4;
    localparam int STALL  = 50;
    localparam int PH     = 20;

    logic       CLK = 1'b0;
    logic       BTN_N = 1'b0;
    logic [6:0] seg_n = 7'h7F;
    logic       dig_sel = 1'b0;
    logic [3:0] ones, tens;
    logic       ones_blank, tens_blank, frame_valid, frame_err, value_changed, stalled;

    seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .STALL_CYCLES(STALL)) dut (
        .CLK           (CLK),
        .BTN_N         (BTN_N),
        .seg_n         (seg_n),
        .dig_sel       (dig_sel),
        .ones          (ones),
        .tens          (tens),
        .ones_blank    (ones_blank),
        .tens_blank    (tens_blank),
        .frame_valid   (frame_valid),
        .frame_err     (frame_err),
        .value_changed (value_changed),
        .stalled       (stalled)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] o;
        logic [3:0] t;
        logic       ob;
        logic       tb;
        logic       err;
        logic       chg;
    } frame_t;

    typedef struct {
        logic [6:0] ones_pat;
        logic [6:0] tens_pat;
        frame_t     exp;
    } vec_t;

    frame_t exp_q[$];
    vec_t   vecs[13];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic phase(input logic d, input logic [6:0] pat, input int n);
        @(posedge CLK);
        #1;
        dig_sel = d;
        seg_n   = ~pat;
        repeat (n - 1) @(posedge CLK);
    endtask

    task automatic frame(input logic [6:0] op, input logic [6:0] tp, input frame_t e);
        phase(1'b0, op, PH);
        exp_q.push_back(e);
        phase(1'b1, tp, PH);
        check("frame_delivered", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every accepted frame must match the oldest pending expectation
    always @(negedge CLK) begin
        if (BTN_N) begin
            if (frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    check("frame_fields",
                          32'({ones, tens, ones_blank, tens_blank, frame_err, value_changed}),
                          32'(exp_q.pop_front()));
                end
            end else begin
                check("idle_pulses", 32'({frame_err, value_changed}), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv_first, fv_count;
        logic exp_stall;

        vecs[0]  = '{7'h06, 7'h5B, '{4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[1]  = '{7'h06, 7'h5B, '{4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[2]  = '{7'h01, 7'h7F, '{4'h1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[3]  = '{7'h71, 7'h00, '{4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1}};
        vecs[4]  = '{7'h3F, 7'h3F, '{4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[5]  = '{7'h7C, 7'h39, '{4'hB, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[6]  = '{7'h5E, 7'h79, '{4'hD, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[7]  = '{7'h3F, 7'h49, '{4'hD, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[8]  = '{7'h00, 7'h00, '{4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1}};
        vecs[9]  = '{7'h6F, 7'h07, '{4'h9, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[10] = '{7'h7D, 7'h6D, '{4'h6, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[11] = '{7'h4F, 7'h66, '{4'h3, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[12] = '{7'h77, 7'h7F, '{4'hA, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1}};

        // Reset held while the pins churn
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            seg_n   = 7'($urandom);
            dig_sel = 1'($urandom);
            @(negedge CLK);
            check("reset_outputs",
                  32'({ones, tens, ones_blank, tens_blank, frame_valid, frame_err, value_changed, stalled}),
                  32'd0);
        end
        @(posedge CLK);
        #1;
        BTN_N   = 1'b1;
        dig_sel = 1'b0;
        seg_n   = ~7'h00;

        // First dig_sel edge is a tens phase with nothing pending: discarded
        phase(1'b1, 7'h5B, PH);
        for (int i = 0; i < 13; i++)
            frame(vecs[i].ones_pat, vecs[i].tens_pat, vecs[i].exp);

        // Latency: tens phase starts at edge k, frame_valid in the cycle after edge k+2+STABLE
        phase(1'b0, 7'h06, PH);
        exp_q.push_back('{4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(posedge CLK);
        #1;
        dig_sel  = 1'b1;
        seg_n    = ~7'h3F;
        fv_first = -1;
        fv_count = 0;
        for (int j = 0; j < PH; j++) begin
            @(negedge CLK);
            if (frame_valid) begin
                fv_count++;
                if (fv_first < 0) fv_first = j;
            end
        end
        check("latency_cycle", 32'(fv_first), 32'(2 + STABLE));
        check("latency_pulse_count", 32'(fv_count), 32'd1);
        frame(7'h06, 7'h3F, '{4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});

        // Glitch rejection: dig_sel toggles every 3 cycles
        for (int i = 0; i < 34; i++)
            phase(1'(i % 2), 7'h06, 3);
        check("glitch_hold", 32'({ones, tens, ones_blank, tens_blank}), 32'({4'h1, 4'h0, 2'b00}));
        frame(7'h06, 7'h3F, '{4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});

        // Repeated ones phase: latest ones capture wins, one frame
        phase(1'b0, 7'h4F, PH);
        frame(7'h06, 7'h5B, '{4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1});

        // Reset after the ones capture discards it
        phase(1'b0, 7'h66, PH);
        @(posedge CLK);
        #1;
        BTN_N = 1'b0;
        @(negedge CLK);
        check("midframe_reset_outputs", 32'({ones, tens, frame_valid}), 32'd0);
        @(posedge CLK);
        #1;
        BTN_N = 1'b1;
        phase(1'b1, 7'h6D, PH);
        check("no_frame_after_reset", 32'({ones, tens, ones_blank, tens_blank}), 32'd0);
        frame(7'h07, 7'h7F, '{4'h7, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1});

        // Stall: dig_sel held high for more than STALL cycles
        phase(1'b0, 7'h06, PH);
        exp_q.push_back('{4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1});
        @(posedge CLK);
        #1;
        dig_sel = 1'b1;
        seg_n   = ~7'h5B;
`ifdef SEG7_SCAN_DECODER_STALL_EN
        exp_stall = 1'b1;
`else
        exp_stall = 1'b0;
`endif
        for (int j = 0; j < 62; j++) begin
            @(negedge CLK);
            if (j == 45) check("stall_early", 32'(stalled), 32'd0);
            if (j == 61) check("stall_set", 32'(stalled), 32'(exp_stall));
        end
        check("stall_frame_delivered", 32'(exp_q.size()), 32'd0);
        @(posedge CLK);
        #1;
        dig_sel = 1'b0;
        seg_n   = ~7'h06;
        repeat (4) @(negedge CLK);
        check("stall_cleared", 32'(stalled), 32'd0);
        repeat (PH - 4) @(posedge CLK);
        exp_q.push_back('{4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0});
        phase(1'b1, 7'h5B, PH);

        repeat (10) @(posedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Monitor and decoder for the multiplexed two-digit 7-segment PMOD drive that the stopwatch produces on P1A1-P1A4 and P1A7-P1A10.
- Samples the active-low segment lines and the digit-select line, waits for each digit phase to settle, and maps each segment pattern back to a 4-bit hex digit.
- Publishes a complete ones/tens frame with a valid pulse.
- Used as a self-check block in stopwatch benches and as a loopback checker on hardware.

Parameters:
- STABLE_CYCLES, 4: consecutive unchanged synchronised cycles required before a digit phase is sampled; legal range 1..255.
- STALL_CYCLES, 1000000: digit-select inactivity limit for the stall flag; used only when the optional feature is compiled in.

Ports:
- CLK  in  1  system clock.
- BTN_N  in  1  asynchronous active-low reset.
- seg_n  in  7  segment lines, active low, bit order {g,f,e,d,c,b,a}.
- dig_sel  in  1  digit select: 0 = ones (right) digit, 1 = tens (left) digit.
- ones  out  4  last accepted ones digit.
- tens  out  4  last accepted tens digit.
- ones_blank  out  1  ones digit was all segments off.
- tens_blank  out  1  tens digit was all segments off.
- frame_valid  out  1  one-cycle pulse when a full frame is accepted.
- frame_err  out  1  one-cycle pulse, coincident with frame_valid, when the frame held an undecodable pattern.
- value_changed  out  1  one-cycle pulse, coincident with frame_valid, when the accepted {tens,ones,blanks} differ from the previous accepted frame.
- stalled  out  1  level output; optional feature only.

Behaviour:
- Reset (BTN_N=0, asynchronous): all outputs 0, synchronisers 0, state IDLE, stable counter 0, ones-captured flag 0.
- Input path: seg_n and dig_sel each pass through a 2-FF synchroniser. seg_n is inverted internally to active-high pat[6:0].
- Stability counter: cleared whenever synchronised {dig_sel,pat} differs from the previous cycle; otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - IDLE: waits for the first synchronised dig_sel edge, then goes to SETTLE. Digits visible before any dig_sel edge are never captured.
  - SETTLE: when the counter reaches STABLE_CYCLES, captures the current phase and goes to HOLD.
  - HOLD: exactly one capture per phase. A dig_sel change moves to SETTLE. A pattern change with dig_sel unchanged also returns to SETTLE, and the phase is recaptured; the latest capture wins.
- Decode table (active-high pattern to digit):
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7
  - 0x7F=8, 0x6F=9, 0x77=A, 0x7C=b, 0x39=C, 0x5E=d, 0x79=E, 0x71=F
  - 0x00 = blank (digit value 0, blank=1).
  - Any other pattern is bad.
- Frame rule:
  - Ones capture stores the pending ones value and sets the ones-captured flag.
  - A tens capture with the flag set completes the frame. On that edge, register ones/tens/blanks, pulse frame_valid, and clear the flag.
  - A tens capture with the flag clear is discarded: no frame, no error.
- Bad pattern in either digit of a frame: frame_valid=1 and frame_err=1, but ones/tens/blanks keep their previous values and value_changed=0.
- Latency: if the tens pattern and dig_sel change at the pins on edge k and then hold, frame_valid is high for exactly the cycle following edge k+2+STABLE_CYCLES.
- Repeated ones phase (ones, ones, tens): the later ones capture overwrites the pending value. Only one frame results.
- dig_sel toggling faster than STABLE_CYCLES: no captures and no frames. Outputs hold.
- Reset mid-frame: the pending ones value and flag are discarded; the FSM returns to IDLE.

Optional Feature:
- Macro: SEG7_SCAN_DECODER_STALL_EN.
- Defined:
  - A counter of cycles since the last synchronised dig_sel edge, saturating at STALL_CYCLES.
  - stalled=1 while the counter equals STALL_CYCLES; stalled=0 on the cycle after the next edge.
  - The counter resets to 0 on reset and on every edge.
- Undefined: stalled is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry pattern constants SEG7_PAT_0..SEG7_PAT_F and SEG7_PAT_BLANK;
  - segment bit-index constants SEG_A..SEG_G;
  - the FSM state encoding (IDLE, SETTLE, HOLD).
- The stopwatch's segment encoder shares this package so the two cannot diverge.
- One natural sub-module: seg7_pat_decode, combinational pattern to {digit[3:0], blank, bad}, instantiated once on the sampled pattern.

Test Plan:
- Reset hold: BTN_N=0 with random seg_n/dig_sel toggles -> all outputs 0. Release, then drive ones=0x06 and tens=0x5B (active-high), 20 cycles per phase -> frame_valid pulse with ones=1, tens=2, value_changed=1.
- Latency: STABLE_CYCLES=4, switch to tens phase (pattern 0x3F) at edge k -> frame_valid exactly in the cycle after edge k+6. Repeat the same frame -> frame_valid=1, value_changed=0.
- Glitch rejection: toggle dig_sel every 3 cycles for 100 cycles with STABLE_CYCLES=4 -> no frame_valid, outputs unchanged.
- Bad pattern: ones=0x01, tens=0x7F -> frame_valid=1, frame_err=1, ones/tens keep prior values 1/2.
- Blank plus wrap: ones=0x71 (F), tens=0x00 -> ones=F, tens_blank=1, tens=0. Next frame 0x3F/0x3F -> ones=0, tens=0, tens_blank=0, value_changed=1.
- Reset mid-frame and stall (SEG7_SCAN_DECODER_STALL_EN, STALL_CYCLES=50):
  - Assert BTN_N=0 after the ones capture, release, then a tens phase only -> no frame.
  - Hold dig_sel constant 60 cycles -> stalled=1 from the 51st cycle; cleared after the next edge.
